// File: rtl/updown_counter_param_pkg.sv
// rtl/updown_counter_param_pkg.sv - shared mode constants and operation decode for the up/down counter
package updown_counter_param_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    // load outranks enable, enable outranks hold
    function automatic op_e decode_op(input logic load, input logic en, input logic up_dn);
        op_e op;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = up_dn ? OP_INC : OP_DEC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// rtl/updown_counter_param_if.sv - control and status bundle of the up/down counter
interface updown_counter_param_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/dff_ar.sv
// rtl/dff_ar.sv - D register with asynchronous active-low clear to zero
module dff_ar #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load clamp, wrap/saturate and tc/wrap flags
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int MODE    = MODE_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_CNT    = WIDTH'(MODULUS - 1);
    localparam bit               FULL_RANGE = (longint'(MODULUS) == (longint'(1) << WIDTH));

    if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("updown_counter_param: MODULUS must lie in 2..2**WIDTH");
    end

    logic             over_range;
    logic             load_over;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    op_e              op;

    // with a full-range modulus no code is out of range, so skip the compares entirely
    if (FULL_RANGE) begin : g_full
        assign over_range = 1'b0;
        assign load_over  = 1'b0;
    end else begin : g_part
        assign over_range = bus.count > MAX_CNT;
        assign load_over  = bus.load_val > MAX_CNT;
    end

    assign at_max  = (bus.count == MAX_CNT);
    assign at_zero = (bus.count == '0);

    always_comb begin
        count_d = bus.count;
        wrap_d  = 1'b0;
        op      = decode_op(bus.load, bus.en, bus.up_dn);
        case (op)
            OP_LOAD: begin
                count_d = load_over ? MAX_CNT : bus.load_val;
            end
            OP_INC: begin
                if (over_range) begin
                    count_d = '0;
                end else if (at_max) begin
                    if (MODE == MODE_WRAP) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = bus.count + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (over_range) begin
                    count_d = '0;
                end else if (at_zero) begin
                    if (MODE == MODE_WRAP) begin
                        count_d = MAX_CNT;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = bus.count - WIDTH'(1);
                end
            end
            default: begin
                if (over_range) begin
                    count_d = '0;
                end
            end
        endcase
    end

    assign bus.tc = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

    dff_ar #(.WIDTH(WIDTH)) u_count (
        .clk   (clk),
        .reset (reset),
        .d     (count_d),
        .q     (bus.count)
    );

    dff_ar #(.WIDTH(1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .d     (wrap_d),
        .q     (bus.wrap)
    );

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - randomized and directed bench for three counter configurations against a behavioural model
module tb_updown_counter_param;

    localparam int N = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b0;
    logic       load     = 1'b0;
    logic [2:0] load_val = '0;

    int    checks = 0;
    int    errors = 0;
    int    mods[N]  = '{8, 6, 6};
    bit    sats[N]  = '{1'b0, 1'b0, 1'b1};
    string names[N] = '{"m8_wrap", "m6_wrap", "m6_sat"};
    int    m_cnt[N];
    int    m_wrap[N];

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(3)) bus_a ();
    updown_counter_param_if #(.WIDTH(3)) bus_b ();
    updown_counter_param_if #(.WIDTH(3)) bus_c ();

    assign bus_a.en = en;  assign bus_a.up_dn = up_dn;  assign bus_a.load = load;  assign bus_a.load_val = load_val;
    assign bus_b.en = en;  assign bus_b.up_dn = up_dn;  assign bus_b.load = load;  assign bus_b.load_val = load_val;
    assign bus_c.en = en;  assign bus_c.up_dn = up_dn;  assign bus_c.load = load;  assign bus_c.load_val = load_val;

    updown_counter_param #(.WIDTH(3), .MODULUS(8), .MODE(0)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    updown_counter_param #(.WIDTH(3), .MODULUS(6), .MODE(0)) u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
    updown_counter_param #(.WIDTH(3), .MODULUS(6), .MODE(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

    task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs_v, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] get_count(input int i);
        case (i)
            0:       return 32'(bus_a.count);
            1:       return 32'(bus_b.count);
            default: return 32'(bus_c.count);
        endcase
    endfunction

    function automatic logic [31:0] get_tc(input int i);
        case (i)
            0:       return 32'(bus_a.tc);
            1:       return 32'(bus_b.tc);
            default: return 32'(bus_c.tc);
        endcase
    endfunction

    function automatic logic [31:0] get_wrap(input int i);
        case (i)
            0:       return 32'(bus_a.wrap);
            1:       return 32'(bus_b.wrap);
            default: return 32'(bus_c.wrap);
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 0;
        end
    endfunction

    // the counter seen as a number on a ring 0..mod-1, or a clamped line when saturating
    function automatic void model_step(input bit e, input bit u, input bit l, input int lv);
        for (int i = 0; i < N; i++) begin
            m_wrap[i] = 0;
            if (l) begin
                m_cnt[i] = (lv < mods[i]) ? lv : mods[i] - 1;
            end else if (e) begin
                int target;
                target = m_cnt[i] + (u ? 1 : -1);
                if (target < 0 || target >= mods[i]) begin
                    if (!sats[i]) begin
                        m_cnt[i]  = (target + mods[i]) % mods[i];
                        m_wrap[i] = 1;
                    end
                end else begin
                    m_cnt[i] = target;
                end
            end
        end
    endfunction

    function automatic int model_tc(input int i);
        int next_up;
        int next_dn;
        next_up = m_cnt[i] + 1;
        next_dn = m_cnt[i] - 1;
        if (!en) return 0;
        return (up_dn ? (next_up >= mods[i]) : (next_dn < 0)) ? 1 : 0;
    endfunction

    task automatic step(input bit e, input bit u, input bit l, input int lv);
        @(negedge clk);
        en = e;
        up_dn = u;
        load = l;
        load_val = 3'(lv);
        #1;
        for (int i = 0; i < N; i++) check({"tc ", names[i]}, get_tc(i), model_tc(i));
        @(posedge clk);
        #1;
        model_step(e, u, l, lv);
        for (int i = 0; i < N; i++) begin
            check({"count ", names[i]}, get_count(i), m_cnt[i]);
            check({"wrap ", names[i]}, get_wrap(i), m_wrap[i]);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        en = 1'b0;
        load = 1'b0;
        reset = 1'b1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            check({"async count ", names[i]}, get_count(i), 0);
            check({"async wrap ", names[i]}, get_wrap(i), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) check({"held count ", names[i]}, get_count(i), 0);
        release_reset();
    endtask

    initial begin
        en = 1'b1;
        up_dn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            check({"rst count ", names[i]}, get_count(i), 0);
            check({"rst wrap ", names[i]}, get_wrap(i), 0);
            check({"rst tc ", names[i]}, get_tc(i), 1);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) check({"rst hold ", names[i]}, get_count(i), 0);
        release_reset();

        repeat (10) step(1, 1, 0, 0);

        async_reset();
        repeat (3) step(1, 0, 0, 0);

        step(0, 0, 1, 4);
        repeat (3) step(1, 1, 0, 0);
        repeat (7) step(1, 0, 0, 0);

        step(1, 1, 1, 7);
        step(0, 1, 1, 2);
        repeat (5) step(0, 1'($urandom), 0, 0);

        step(0, 0, 1, 3);
        for (int k = 0; k < 4; k++) step(1, (k % 2) == 0, 0, 0);
        step(0, 1, 1, 7);
        step(1, 0, 0, 0);

        step(0, 1, 1, 4);
        step(1, 1, 0, 0);
        async_reset();
        step(1, 1, 0, 0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 7)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
